// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit
// Iterative RV32M multiply/divide execute unit. Operands are captured from the
// register file when a decoded M-extension op arrives. A radix-2 shift-add
// multiplier and a restoring divider share one 64-bit working register. The
// unit stalls the core while it works and writes the result back through the
// rd port. Every op takes the same number of cycles, including the special
// cases.
module rv32m_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    if (neg) cond_neg = ZERO_W - v;
    else     cond_neg = v;
  endfunction

  // Magnitude of an operand; unsigned operands are already magnitudes.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    magnitude = cond_neg(v, is_signed & v[XLEN-1]);
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         op_r;
  logic [XLEN-1:0]    rs1_r, rs2_r;
  logic [4:0]         rd_addr_r;
  logic [XLEN-1:0]    mag_a_r, mag_b_r;
  logic               div_zero_r, ovf_r, neg_lo_r, neg_rem_r;
  logic [2*XLEN-1:0]  prod_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               load_r;
  logic [XLEN-1:0]    rd_data_r;
  logic               busy_r, done_r, wren_r;

  logic               is_div_s, rs1_signed_s, rs2_signed_s;
  logic [XLEN:0]      mul_sum_s;
  logic [2*XLEN-1:0]  mul_next_s;
  logic [XLEN:0]      div_shift_s;
  logic               div_ge_s;
  logic [XLEN-1:0]    div_rem_s;
  logic [2*XLEN-1:0]  div_next_s;
  logic [2*XLEN-1:0]  prod_fix_s;
  logic [XLEN-1:0]    quo_s, rem_s, fix_res_s;

  // Operand signedness decoded from the captured funct3.
  always_comb begin
    is_div_s = op_r[2];
    if (is_div_s) begin
      rs1_signed_s = ~op_r[0];
      rs2_signed_s = ~op_r[0];
    end else begin
      rs1_signed_s = (op_r[1:0] != 2'b11);
      rs2_signed_s = ~op_r[1];
    end
  end

  // One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]}
                + (prod_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, prod_r[XLEN-1:1]};
    div_shift_s = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
    if (div_ge_s) div_rem_s = div_shift_s[XLEN-1:0] - mag_b_r;
    else          div_rem_s = div_shift_s[XLEN-1:0];
    div_next_s  = {div_rem_s, prod_r[XLEN-2:0], div_ge_s};
  end

  // Sign correction and result selection, including forced special results.
  always_comb begin
    if (neg_lo_r) prod_fix_s = {(2*XLEN){1'b0}} - prod_r;
    else          prod_fix_s = prod_r;
    quo_s     = cond_neg(prod_r[XLEN-1:0], neg_lo_r);
    rem_s     = cond_neg(prod_r[2*XLEN-1:XLEN], neg_rem_r);
    fix_res_s = ZERO_W;
    case (op_r)
      3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero_r)  fix_res_s = ALL_ONES;
        else if (ovf_r)  fix_res_s = MIN_NEG;
        else             fix_res_s = quo_s;
      end
      3'b110, 3'b111: begin
        if (div_zero_r)  fix_res_s = rs1_r;
        else if (ovf_r)  fix_res_s = ZERO_W;
        else             fix_res_s = rem_s;
      end
      default:                fix_res_s = ZERO_W;
    endcase
  end

  // Next-state logic: fixed-length walk through the sequence once started.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_s = ST_PREP;
        else         state_s = ST_IDLE;
      end
      ST_PREP: state_s = ST_CALC;
      ST_CALC: begin
        if (!load_r && (cnt_r == CNT_ZERO)) state_s = ST_FIX;
        else                                state_s = ST_CALC;
      end
      ST_FIX:  state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_r       <= 3'd0;
      rs1_r      <= ZERO_W;
      rs2_r      <= ZERO_W;
      rd_addr_r  <= 5'd0;
      mag_a_r    <= ZERO_W;
      mag_b_r    <= ZERO_W;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_rem_r  <= 1'b0;
      prod_r     <= {(2*XLEN){1'b0}};
      cnt_r      <= CNT_ZERO;
      load_r     <= 1'b0;
      rd_data_r  <= ZERO_W;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            op_r      <= i_funct3;
            rs1_r     <= i_rs1_data;
            rs2_r     <= i_rs2_data;
            rd_addr_r <= i_rd_addr;
          end
        end
        ST_PREP: begin
          mag_a_r    <= magnitude(rs1_r, rs1_signed_s);
          mag_b_r    <= magnitude(rs2_r, rs2_signed_s);
          div_zero_r <= (rs2_r == ZERO_W);
          ovf_r      <= is_div_s & ~op_r[0] & (rs1_r == MIN_NEG) & (rs2_r == ALL_ONES);
          neg_lo_r   <= (rs1_signed_s & rs1_r[XLEN-1]) ^ (rs2_signed_s & rs2_r[XLEN-1]);
          neg_rem_r  <= rs1_signed_s & rs1_r[XLEN-1];
          cnt_r      <= CNT_LAST;
          load_r     <= 1'b1;
        end
        ST_CALC: begin
          if (load_r) begin
            // First CALC cycle seeds the working register with the
            // multiplier (mul) or dividend (div) magnitude.
            prod_r <= {ZERO_W, (is_div_s ? mag_a_r : mag_b_r)};
            load_r <= 1'b0;
          end else begin
            prod_r <= is_div_s ? div_next_s : mul_next_s;
            if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
            else                   cnt_r <= CNT_ZERO;
          end
        end
        ST_FIX:  rd_data_r <= fix_res_s;
        default: ;
      endcase
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      wren_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
      wren_r <= (state_s == ST_DONE) && (rd_addr_r != 5'd0);
    end
  end

  // Stall is combinational so the start cycle itself already holds the PC.
  assign o_stall   = ((state_r == ST_IDLE) && i_start) || (state_r == ST_PREP)
                  || (state_r == ST_CALC) || (state_r == ST_FIX);
  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_rd_addr = rd_addr_r;
  assign o_rd_data = rd_data_r;
  assign o_rd_wren = wren_r;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit
// Randomized scoreboard bench: the driver pushes the expected writeback (data,
// rd, wren, completion cycle) for every op it starts; an independent monitor
// pops and compares on every o_done pulse.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        stall, busy, done, wren;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wren;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  exp_t sb_q[$];
  vec_t dir[12];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rv32m_muldiv_unit dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_funct3   (f3),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_rd_addr  (rd),
    .o_stall    (stall),
    .o_busy     (busy),
    .o_done     (done),
    .o_rd_addr  (rd_addr_o),
    .o_rd_data  (rd_data_o),
    .o_rd_wren  (wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32M results from plain 64-bit and 32-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    qa = a;
    qb = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return qa / qb;
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return qa % qb;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_garbage();
    start = 1'($urandom_range(0, 1));
    f3    = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
    rd    = 5'($urandom);
  endtask

  // Start one op from an IDLE cycle (called just after a rising edge) and
  // return just after the rising edge that brings the unit back to IDLE.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] res);
    exp_t e;
    start = 1'b1; f3 = op; rs1 = a; rs2 = b; rd = r;
    e.data = res; e.addr = r; e.wren = (r != 5'd0); e.cyc = cyc + 36;
    sb_q.push_back(e);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_start: o_stall=%b expected 1 (funct3=%0d)", stall, op);
    end
    for (int i = 1; i <= 36; i++) begin
      @(posedge clk); #1;
      drive_garbage();
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: data=%h rd=%0d cycle=%0d, nothing outstanding",
                 rd_data_o, rd_addr_o, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rd_data_o !== e.data || rd_addr_o !== e.addr || wren !== e.wren ||
            cyc != e.cyc || stall !== 1'b0) begin
          n_fail++;
          $display("FAIL writeback: got data=%h rd=%0d wren=%b cyc=%0d stall=%b, expected data=%h rd=%0d wren=%b cyc=%0d stall=0",
                   rd_data_o, rd_addr_o, wren, cyc, stall, e.data, e.addr, e.wren, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    exp_t        e;

    rst = 1'b1; start = 1'b0; f3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;

    dir[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    dir[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    dir[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF};
    dir[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE};
    dir[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD};
    dir[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF};
    dir[6]  = '{3'b101, 32'd100,       32'd7,         5'd9,  32'd14};
    dir[7]  = '{3'b111, 32'd100,       32'd7,         5'd0,  32'd2};
    dir[8]  = '{3'b101, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF};
    dir[9]  = '{3'b110, 32'd100,       32'd0,         5'd11, 32'd100};
    dir[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    dir[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, stall, done, wren, rd_addr_o, rd_data_o} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b stall=%b done=%b wren=%b rd=%0d data=%h, expected all 0",
               busy, stall, done, wren, rd_addr_o, rd_data_o);
    end
    @(posedge clk); #1;

    // Directed corner cases with known results.
    for (int i = 0; i < 12; i++) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].rd, dir[i].res);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, 5'($urandom), ref_model(op, a, b));
    end

    // i_start held high with rd=0: one writeback, then a restart from IDLE.
    a = $urandom; b = $urandom;
    start = 1'b1; f3 = 3'b000; rs1 = a; rs2 = b; rd = 5'd0;
    e.data = ref_model(3'b000, a, b); e.addr = 5'd0; e.wren = 1'b0; e.cyc = cyc + 36;
    sb_q.push_back(e);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL hold_stall_start: o_stall=%b expected 1", stall);
    end
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL hold_stall: o_stall=%b expected 1 at offset %0d", stall, i);
      end
    end
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL hold_stall_done: o_stall=%b expected 0", stall);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL hold_idle: busy=%b stall=%b expected busy=0 stall=1", busy, stall);
    end
    e.cyc = cyc + 36;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (36) begin @(posedge clk); #1; end

    // Reset during the 10th CALC cycle aborts without writeback.
    start = 1'b1; f3 = 3'b000; rs1 = $urandom; rs2 = $urandom; rd = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, stall, done, wren, rd_addr_o, rd_data_o} !== 41'd0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b stall=%b done=%b wren=%b rd=%0d data=%h, expected all 0",
               busy, stall, done, wren, rd_addr_o, rd_data_o);
    end
    repeat (40) begin @(posedge clk); #1; end
    a = $urandom; b = $urandom;
    issue(3'b000, a, b, 5'd17, ref_model(3'b000, a, b));

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d writebacks still outstanding, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
